// File: rtl/blk_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : blk_rx_frame
// Description : UART 8N1 receive path. Received bytes are written to the
//               frame memory at consecutive addresses from 0. A frame closes
//               on an idle gap or on the length cap, and o_mem_wdone then
//               carries the byte count to the transmit side.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IDLE_BITS    = 20,
  parameter int unsigned MAX_BYTES    = 1023
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_mem_wen,
  output logic [9:0] o_mem_waddr,
  output logic [7:0] o_mem_wdata,
  output logic       o_mem_wdone,
  output logic [9:0] o_mem_byte,
  output logic       o_frame_err,
  output logic       o_busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  // Start bit is re-checked half a bit in, so every later sample is mid-bit.
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'((CLKS_PER_BIT - 1) / 2);

  localparam logic [2:0]  c_IDX_ONE   = 3'd1;
  localparam logic [2:0]  c_IDX_LAST  = 3'd7;
  localparam logic [9:0]  c_CNT10_ONE = 10'd1;
  localparam logic [9:0]  c_MAX_BYTES = 10'(MAX_BYTES);
  localparam logic [19:0] c_TMR_ONE   = 20'd1;
  // Timeout fires on the cycle the timer would reach IDLE_BITS*CLKS_PER_BIT.
  localparam logic [19:0] c_IDLE_LAST = 20'(IDLE_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic               r_rx_meta;
  logic               r_rx_s;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;

  logic               w_start_det;
  logic               w_byte_valid;
  logic               w_frame_err;

  logic [9:0]         r_count;
  logic [19:0]        r_timer;
  logic               w_timeout;
  logic               w_cap;
  logic               w_close;

  logic               r_wen;
  logic [9:0]         r_waddr;
  logic [7:0]         r_wdata;
  logic               r_wdone;
  logic [9:0]         r_byte;
  logic               r_err;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Bit FSM state, bit-time counter, bit index and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Bit FSM next-state and per-byte events
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_start_det  = 1'b0;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_start_det = 1'b1;
        end
      end

      S_START: begin
        if (r_cnt == c_CNT_HALF) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          // Line back high at mid start bit: a glitch, silently ignored.
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      S_DATA: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};  // LSB arrives first
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + c_IDX_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      S_STOP: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_byte_valid = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame closure conditions
  // --------------------------------------------------------------------------
  always_comb begin
    // A start detected on the terminal cycle keeps the frame open.
    w_timeout = (r_state == S_IDLE) && (r_count != '0) && !w_start_det &&
                (r_timer == c_IDLE_LAST);
    // Count only sits at the cap for the one cycle after the capping write.
    w_cap     = (r_count == c_MAX_BYTES);
    w_close   = w_timeout || w_cap;
  end

  // --------------------------------------------------------------------------
  // Idle timer: runs only while idle inside an open frame
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_timer <= '0;
    end else if (w_start_det || w_close) begin
      r_timer <= '0;
    end else if ((r_state == S_IDLE) && (r_count != '0)) begin
      r_timer <= r_timer + c_TMR_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Frame byte count
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (w_close) begin
      r_count <= '0;
    end else if (w_byte_valid) begin
      r_count <= r_count + c_CNT10_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Memory write port; address and data hold between writes
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_byte_valid;
      if (w_byte_valid) begin
        r_waddr <= r_count;
        r_wdata <= r_shift;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame-complete handshake, held byte count and framing-error pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wdone <= 1'b0;
      r_byte  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wdone <= w_close;
      r_err   <= w_frame_err;
      if (w_close) begin
        r_byte <= r_count;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_mem_wen   = r_wen;
  assign o_mem_waddr = r_waddr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wdone = r_wdone;
  assign o_mem_byte  = r_byte;
  assign o_frame_err = r_err;
  assign o_busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_blk_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_blk_rx_frame
// Description : Self-checking bench for blk_rx_frame with a timing-aware
//               transaction model and randomized UART traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blk_rx_frame;

  localparam int CPB = 16;
  localparam int IB  = 4;
  localparam int MB  = 4;
  // Cycles from driving the start edge to the start-bit recheck: 2 sync
  // flops, 1 detect cycle, then half a bit.
  localparam int T_CHK  = 3 + (CPB - 1) / 2 + 1;
  // Stop-bit sample (and write/err visibility) relative to start edge.
  localparam int T_STOP = T_CHK + 9 * CPB;
  localparam int T_IDLE = IB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       o_mem_wen;
  logic [9:0] o_mem_waddr;
  logic [7:0] o_mem_wdata;
  logic       o_mem_wdone;
  logic [9:0] o_mem_byte;
  logic       o_frame_err;
  logic       o_busy;

  blk_rx_frame #(
    .CLKS_PER_BIT(CPB),
    .IDLE_BITS   (IB),
    .MAX_BYTES   (MB)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_uart_rx  (rx),
    .o_mem_wen  (o_mem_wen),
    .o_mem_waddr(o_mem_waddr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_wdone(o_mem_wdone),
    .o_mem_byte (o_mem_byte),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int cyc; logic [9:0] addr; logic [7:0] data; } wev_t;
  typedef struct { int cyc; logic [9:0] cnt; } dev_t;

  // Model: expected events stamped with the cycle they must be visible.
  wev_t wq[$];
  dev_t dq[$];
  int   eq[$];
  int   m_count = 0;
  bit   tent = 1'b0;   // back of dq is a speculative idle-timeout closure
  int   tent_cyc = 0;
  logic [9:0] m_last_addr = '0;
  logic [7:0] m_last_data = '0;
  logic [9:0] m_last_byte = '0;

  // Observation logs for the literal expectations.
  wev_t obs_w[$];
  dev_t obs_d[$];
  int   obs_e = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A new start edge at cycle c: decide whether the pending idle closure
  // still happens (start seen too late) or is cancelled (frame continues).
  task automatic model_start(input int c);
    if (tent) begin
      if (c + 3 <= tent_cyc) begin
        void'(dq.pop_back());
      end else begin
        m_count = 0;
      end
      tent = 1'b0;
    end
  endtask

  // Line went idle at cycle e with an open frame: closure T_IDLE later.
  task automatic model_idle(input int e);
    if (m_count > 0) begin
      dq.push_back('{e + T_IDLE, 10'(m_count)});
      tent     = 1'b1;
      tent_cyc = e + T_IDLE;
    end
  endtask

  task automatic model_reset();
    wq.delete();
    dq.delete();
    eq.delete();
    m_count     = 0;
    tent        = 1'b0;
    m_last_addr = '0;
    m_last_data = '0;
    m_last_byte = '0;
  endtask

  task automatic clear_logs();
    obs_w.delete();
    obs_d.delete();
    obs_e = 0;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] data, input bit stop_ok, input int gap);
    int c;
    c = cyc;
    model_start(c);
    if (stop_ok) begin
      wq.push_back('{c + T_STOP, 10'(m_count), data});
      m_count++;
      if (m_count == MB) begin
        dq.push_back('{c + T_STOP + 1, 10'(MB)});
        m_count = 0;
      end else begin
        model_idle(c + T_STOP);
      end
    end else begin
      eq.push_back(c + T_STOP);
      // Low line after the stop sample is taken as a new start, rejected as
      // a glitch once the line is back high; idle resumes after that recheck.
      model_idle(c + T_STOP + 1 + (CPB - 1) / 2 + 1);
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_glitch(input int low, input int gap);
    int c;
    c = cyc;
    model_start(c);
    model_idle(c + T_CHK);
    rx = 1'b0;
    repeat (low) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin : cmp
    bit ew;
    bit ed;
    bit ee;
    #1;
    ew = (wq.size() != 0) && (wq[0].cyc == cyc);
    if (ew) begin
      m_last_addr = wq[0].addr;
      m_last_data = wq[0].data;
      void'(wq.pop_front());
    end
    ed = (dq.size() != 0) && (dq[0].cyc == cyc);
    if (ed) begin
      m_last_byte = dq[0].cnt;
      void'(dq.pop_front());
    end
    ee = (eq.size() != 0) && (eq[0] == cyc);
    if (ee) void'(eq.pop_front());

    check("wen",   32'(o_mem_wen),   32'(ew));
    check("waddr", 32'(o_mem_waddr), 32'(m_last_addr));
    check("wdata", 32'(o_mem_wdata), 32'(m_last_data));
    check("wdone", 32'(o_mem_wdone), 32'(ed));
    check("byte",  32'(o_mem_byte),  32'(m_last_byte));
    check("ferr",  32'(o_frame_err), 32'(ee));

    if (o_mem_wen === 1'b1)   obs_w.push_back('{cyc, o_mem_waddr, o_mem_wdata});
    if (o_mem_wdone === 1'b1) obs_d.push_back('{cyc, o_mem_byte});
    if (o_frame_err === 1'b1) obs_e++;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r;
    int g;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_wen",   32'(o_mem_wen),   32'd0);
    check("rst_wdone", 32'(o_mem_wdone), 32'd0);
    check("rst_busy",  32'(o_busy),      32'd0);
    check("rst_byte",  32'(o_mem_byte),  32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Three bytes back-to-back, then idle.
    clear_logs();
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'hA3, 1'b1, 0);
    send_byte(8'h0F, 1'b1, 120);
    check("s1_nwen", obs_w.size(), 3);
    for (int i = 0; i < 3 && i < obs_w.size(); i++)
      check("s1_addr", 32'(obs_w[i].addr), i);
    if (obs_w.size() == 3) begin
      check("s1_d0", 32'(obs_w[0].data), 32'h55);
      check("s1_d1", 32'(obs_w[1].data), 32'hA3);
      check("s1_d2", 32'(obs_w[2].data), 32'h0F);
    end
    check("s1_ndone", obs_d.size(), 1);
    if (obs_d.size() == 1 && obs_w.size() == 3) begin
      check("s1_cnt",   32'(obs_d[0].cnt), 32'd3);
      check("s1_delay", obs_d[0].cyc - obs_w[2].cyc, 64);
    end

    // Six bytes against a cap of four.
    clear_logs();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1, (i == 6) ? 120 : 0);
    check("s2_nwen",   obs_w.size(), 6);
    check("s2_ndone",  obs_d.size(), 2);
    if (obs_w.size() == 6 && obs_d.size() == 2) begin
      check("s2_cap",   32'(obs_d[0].cnt), 32'd4);
      check("s2_capt",  obs_d[0].cyc - obs_w[3].cyc, 1);
      check("s2_a4",    32'(obs_w[4].addr), 32'd0);
      check("s2_a5",    32'(obs_w[5].addr), 32'd1);
      check("s2_d5",    32'(obs_w[5].data), 32'h06);
      check("s2_tail",  32'(obs_d[1].cnt), 32'd2);
    end

    // Framing error, then a good byte.
    clear_logs();
    send_byte(8'h7E, 1'b0, 30);
    send_byte(8'h11, 1'b1, 120);
    check("s3_nerr", obs_e, 1);
    check("s3_nwen", obs_w.size(), 1);
    if (obs_w.size() == 1) begin
      check("s3_addr", 32'(obs_w[0].addr), 32'd0);
      check("s3_data", 32'(obs_w[0].data), 32'h11);
    end

    // Short low pulse on an idle line.
    clear_logs();
    send_glitch(5, 10);
    check("s4_busy", 32'(o_busy), 32'd0);
    repeat (20) @(negedge clk);
    check("s4_nwen",  obs_w.size(), 0);
    check("s4_nerr",  obs_e, 0);
    check("s4_ndone", obs_d.size(), 0);

    // 3.5 bit-time gap keeps the frame open.
    clear_logs();
    send_byte(8'hC3, 1'b1, 56);
    send_byte(8'h3C, 1'b1, 120);
    check("s5_ndone", obs_d.size(), 1);
    if (obs_d.size() == 1) check("s5_cnt", 32'(obs_d[0].cnt), 32'd2);
    if (obs_w.size() == 2) check("s5_a1", 32'(obs_w[1].addr), 32'd1);

    // Reset in the middle of the second byte's data bits.
    send_byte(8'hA5, 1'b1, 0);
    model_start(cyc);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("s6_wen",   32'(o_mem_wen),   32'd0);
    check("s6_wdata", 32'(o_mem_wdata), 32'd0);
    check("s6_byte",  32'(o_mem_byte),  32'd0);
    check("s6_busy",  32'(o_busy),      32'd0);
    check("s6_err",   32'(o_frame_err), 32'd0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_logs();
    send_byte(8'h42, 1'b1, 120);
    check("s6_nwen", obs_w.size(), 1);
    if (obs_w.size() == 1) check("s6_addr", 32'(obs_w[0].addr), 32'd0);
    check("s6_ndone", obs_d.size(), 1);
    if (obs_d.size() == 1) check("s6_cnt", 32'(obs_d[0].cnt), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        g = ($urandom_range(0, 1) != 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(80, 150));
        send_glitch(5, g);
      end else if (r < 20) begin
        g = ($urandom_range(0, 1) != 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(80, 150));
        send_byte(8'($urandom), 1'b0, g);
      end else begin
        g = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(80, 150));
        send_byte(8'($urandom), 1'b1, g);
      end
    end
    repeat (300) @(negedge clk);

    check("drain_wen",   wq.size(), 0);
    check("drain_wdone", dq.size(), 0);
    check("drain_err",   eq.size(), 0);
    check("end_busy",    32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
